// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: button edge detect, IDLE/RUN/PAUSE/LAP FSM,
// count-tick prescaler and clear pulse for the BCD time counter.
module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV = 1000000,
  parameter int unsigned CW       = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       clear_btn,
  input  logic       lap_btn,
  output logic       tick,
  output logic       clr,
  output logic       freeze,
  output logic       running,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LAP   = 2'b11
  } state_e;

  localparam logic [CW-1:0] PCNT_MAX = CW'(TICK_DIV - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   pcnt_q, pcnt_d;
  logic            tick_q, tick_d;
  logic            clr_q, clr_d;
  logic            prev_start_q, prev_start_d;
  logic            prev_clear_q, prev_clear_d;
  logic            prev_lap_q, prev_lap_d;
  logic            press_start, press_clear, press_lap;
  logic            counting;

  // Register process; prev registers reset high so held buttons need a re-press.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pcnt_q       <= '0;
      tick_q       <= 1'b0;
      clr_q        <= 1'b0;
      prev_start_q <= 1'b1;
      prev_clear_q <= 1'b1;
      prev_lap_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      pcnt_q       <= pcnt_d;
      tick_q       <= tick_d;
      clr_q        <= clr_d;
      prev_start_q <= prev_start_d;
      prev_clear_q <= prev_clear_d;
      prev_lap_q   <= prev_lap_d;
    end
  end

  always_comb begin
    prev_start_d = start_btn;
    prev_clear_d = clear_btn;
    prev_lap_d   = lap_btn;
    press_start  = start_btn & ~prev_start_q;
    press_clear  = clear_btn & ~prev_clear_q;
    press_lap    = lap_btn   & ~prev_lap_q;
  end

  // Next state: clear > start > lap, only among presses legal in the state.
  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (press_clear)      clr_d   = 1'b1;
        else if (press_start) state_d = RUN;
      end
      RUN: begin
        if (press_start)      state_d = PAUSE;
        else if (press_lap)   state_d = LAP;
      end
      LAP: begin
        if (press_start)      state_d = PAUSE;
        else if (press_lap)   state_d = RUN;
      end
      PAUSE: begin
        if (press_clear) begin
          state_d = IDLE;
          clr_d   = 1'b1;
        end else if (press_start) begin
          state_d = RUN;
        end
      end
    endcase
  end

  // Prescaler counts only while staying in RUN/LAP; a pause edge holds pcnt.
  always_comb begin
    pcnt_d   = pcnt_q;
    tick_d   = 1'b0;
    counting = state_q[0] & state_d[0];
    if (state_q == IDLE || clr_d) begin
      pcnt_d = '0;
    end else if (counting) begin
      if (pcnt_q == PCNT_MAX) begin
        pcnt_d = '0;
        tick_d = 1'b1;
      end else begin
        pcnt_d = pcnt_q + CW'(1);
      end
    end
  end

  // Outputs decoded straight from registers.
  always_comb begin
    state   = state_q;
    running = state_q[0];
    freeze  = (state_q == LAP);
    tick    = tick_q;
    clr     = clr_q;
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl with TICK_DIV=4: driver queues hand-derived
// expected outputs per cycle, monitor pops and compares one cycle later.
module tb_stopwatch_ctrl;

  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned CW       = 3;

  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_PAUSE = 2;
  localparam int S_LAP   = 3;

  typedef struct packed {
    logic [1:0] st;
    logic       tick;
    logic       clr;
    logic       frz;
    logic       run;
    logic [2:0] pcnt;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_btn = 1'b0;
  logic       clear_btn = 1'b0;
  logic       lap_btn = 1'b0;
  logic       tick, clr, freeze, running;
  logic [1:0] state;

  obs_t  exp_q[$];
  string name_q[$];
  obs_t  e_mon, a_mon;
  string n_mon;
  int    checks = 0;
  int    failures = 0;

  stopwatch_ctrl #(.TICK_DIV(TICK_DIV), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .start_btn(start_btn), .clear_btn(clear_btn), .lap_btn(lap_btn),
    .tick(tick), .clr(clr), .freeze(freeze), .running(running), .state(state)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs at negedge and queue the outputs expected after the next edge.
  task automatic cyc(input int r, input int s, input int c, input int l,
                     input int es, input int et, input int ec, input int ep,
                     input string nm);
    obs_t e;
    @(negedge clk);
    rst       = 1'(r);
    start_btn = 1'(s);
    clear_btn = 1'(c);
    lap_btn   = 1'(l);
    e.st   = 2'(es);
    e.tick = 1'(et);
    e.clr  = 1'(ec);
    e.frz  = (es == S_LAP);
    e.run  = (es == S_RUN) || (es == S_LAP);
    e.pcnt = 3'(ep);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      e_mon = exp_q.pop_front();
      n_mon = name_q.pop_front();
      a_mon = {state, tick, clr, freeze, running, dut.pcnt_q};
      checks++;
      if (a_mon !== e_mon) begin
        failures++;
        $display("FAIL %s: got st=%b tick=%b clr=%b frz=%b run=%b pcnt=%0d, expected st=%b tick=%b clr=%b frz=%b run=%b pcnt=%0d",
                 n_mon, a_mon.st, a_mon.tick, a_mon.clr, a_mon.frz, a_mon.run, a_mon.pcnt,
                 e_mon.st, e_mon.tick, e_mon.clr, e_mon.frz, e_mon.run, e_mon.pcnt);
      end
    end
  end

  initial begin
    // Start held through reset must not register a press.
    cyc(1, 1, 0, 0, S_IDLE, 0, 0, 0, "reset_hold");
    cyc(1, 1, 0, 0, S_IDLE, 0, 0, 0, "reset_hold");
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, S_IDLE, 0, 0, 0, "held_thru_reset");
    cyc(0, 0, 0, 0, S_IDLE, 0, 0, 0, "release");
    cyc(0, 1, 0, 0, S_RUN, 0, 0, 0, "start_from_idle");

    // Cadence: start stays held a few cycles; 10 ticks in 40 cycles.
    for (int i = 1; i <= 40; i++)
      cyc(0, (i < 5) ? 1 : 0, 0, 0, S_RUN, (i % 4 == 0) ? 1 : 0, 0, i % 4, "run_cadence");

    // Pause at pcnt=2, hold 50 cycles, resume -> tick two cycles later.
    cyc(0, 0, 0, 0, S_RUN, 0, 0, 1, "pre_pause");
    cyc(0, 0, 0, 0, S_RUN, 0, 0, 2, "pre_pause");
    cyc(0, 1, 0, 0, S_PAUSE, 0, 0, 2, "pause");
    for (int i = 0; i < 50; i++) cyc(0, 0, 0, 0, S_PAUSE, 0, 0, 2, "paused_hold");
    cyc(0, 1, 0, 0, S_RUN, 0, 0, 2, "resume");
    cyc(0, 0, 0, 0, S_RUN, 0, 0, 3, "resume_count");
    cyc(0, 0, 0, 0, S_RUN, 1, 0, 0, "resume_tick");

    // Clear ignored in RUN and LAP; lap toggles freeze with counting continuing.
    cyc(0, 0, 1, 0, S_RUN, 0, 0, 1, "clear_in_run");
    cyc(0, 0, 0, 0, S_RUN, 0, 0, 2, "after_clear_run");
    cyc(0, 0, 0, 1, S_LAP, 0, 0, 3, "lap_enter");
    cyc(0, 0, 0, 0, S_LAP, 1, 0, 0, "lap_tick");
    cyc(0, 0, 1, 0, S_LAP, 0, 0, 1, "clear_in_lap");
    cyc(0, 0, 0, 0, S_LAP, 0, 0, 2, "lap_count");
    cyc(0, 0, 0, 0, S_LAP, 0, 0, 3, "lap_count");
    cyc(0, 0, 0, 0, S_LAP, 1, 0, 0, "lap_tick2");
    cyc(0, 0, 0, 1, S_RUN, 0, 0, 1, "lap_exit");
    cyc(0, 0, 0, 0, S_RUN, 0, 0, 2, "run_after_lap");
    cyc(0, 0, 0, 1, S_LAP, 0, 0, 3, "lap_again");

    // Pause on the would-be wrap edge: no tick, pcnt holds max, tick on first resumed cycle.
    cyc(0, 1, 0, 0, S_PAUSE, 0, 0, 3, "pause_from_lap_at_wrap");
    cyc(0, 0, 0, 0, S_PAUSE, 0, 0, 3, "paused_at_max");
    cyc(0, 1, 0, 0, S_RUN, 0, 0, 3, "resume_at_max");
    cyc(0, 0, 0, 0, S_RUN, 1, 0, 0, "tick_first_resume_cycle");
    cyc(0, 0, 0, 0, S_RUN, 0, 0, 1, "run_count");

    // Simultaneous presses.
    cyc(0, 1, 0, 1, S_PAUSE, 0, 0, 1, "start_beats_lap_run");
    cyc(0, 0, 0, 0, S_PAUSE, 0, 0, 1, "paused");
    cyc(0, 1, 1, 0, S_IDLE, 0, 1, 0, "clear_beats_start_pause");
    cyc(0, 0, 0, 0, S_IDLE, 0, 0, 0, "clr_one_cycle");

    // Clear and lap in IDLE.
    cyc(0, 0, 1, 0, S_IDLE, 0, 1, 0, "clear_in_idle");
    cyc(0, 0, 1, 0, S_IDLE, 0, 0, 0, "clear_held");
    cyc(0, 0, 0, 0, S_IDLE, 0, 0, 0, "clear_release");
    cyc(0, 0, 0, 1, S_IDLE, 0, 0, 0, "lap_in_idle");
    cyc(0, 0, 0, 0, S_IDLE, 0, 0, 0, "lap_release");

    // Start toggling every cycle presses on every rising level.
    cyc(0, 1, 0, 0, S_RUN, 0, 0, 0, "toggle_press1");
    cyc(0, 0, 0, 0, S_RUN, 0, 0, 1, "toggle_low1");
    cyc(0, 1, 0, 0, S_PAUSE, 0, 0, 1, "toggle_press2");
    cyc(0, 0, 0, 0, S_PAUSE, 0, 0, 1, "toggle_low2");
    cyc(0, 1, 0, 0, S_RUN, 0, 0, 1, "toggle_press3");
    cyc(0, 0, 0, 0, S_RUN, 0, 0, 2, "toggle_low3");
    cyc(0, 0, 0, 0, S_RUN, 0, 0, 3, "run_to_max");

    // Reset on the wrap edge drops the in-flight tick.
    cyc(1, 0, 0, 0, S_IDLE, 0, 0, 0, "reset_at_wrap");
    cyc(0, 0, 0, 0, S_IDLE, 0, 0, 0, "post_reset");
    cyc(0, 1, 1, 0, S_IDLE, 0, 1, 0, "clear_beats_start_idle");
    cyc(0, 0, 0, 0, S_IDLE, 0, 0, 0, "final_idle");

    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expected entries left unchecked, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control sequencer for the stopwatch datapath. Takes the debounced start/stop, clear and lap button levels, detects press edges, runs a four-state control FSM, and drives the time-counter datapath. It drives that datapath through a prescaled count-enable pulse, a one-cycle clear pulse and a display-freeze (lap hold) level. It sits between the debouncers and the BCD time counter / display mux.

## Interface
- `TICK_DIV`, default 1000000: clk cycles per count tick (100 MHz → 10 ms tick); legal range ≥ 2.
- `CW`, default 20: prescaler width; must satisfy 2^CW ≥ TICK_DIV.
- `clk` in 1: system clock; all state changes on rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `start_btn` in 1: debounced start/stop level, 1 = pressed.
- `clear_btn` in 1: debounced clear level, 1 = pressed.
- `lap_btn` in 1: debounced lap level, 1 = pressed.
- `tick` out 1: count-enable pulse to time counter, one cycle wide.
- `clr` out 1: clear pulse to time counter, one cycle wide.
- `freeze` out 1: display holds last latched time while 1.
- `running` out 1: 1 in RUN or LAP.
- `state` out 2: FSM state code.

## Operation
- Edge detect: one prev register per button. `press_x = x_btn & ~prev_x`. On `rst`, prev registers are set to 1, so a button held through reset must be released and pressed again.
- Simultaneous presses in one cycle: clear > start > lap. Only the highest-priority *legal* press acts; the others are discarded, not queued.
- States: IDLE=00, RUN=01, PAUSE=10, LAP=11.
- IDLE: start → RUN. Clear → stay IDLE and pulse `clr`. Lap is ignored.
- RUN: start → PAUSE. Lap → LAP (`freeze`=1). Clear is ignored (a clear press must not fall through to start/lap).
- LAP: counting continues. Lap → RUN (`freeze`=0). Start → PAUSE (`freeze`=0). Clear is ignored.
- PAUSE: start → RUN. Clear → IDLE and pulse `clr`. Lap is ignored.
- Prescaler `pcnt` [CW-1:0]:
  - Increments each cycle while the state is RUN or LAP.
  - At `pcnt == TICK_DIV-1` it wraps to 0 and a tick is generated.
  - Holds its value in PAUSE, so partial ticks are preserved across pause/resume.
  - Forced to 0 in IDLE and whenever `clr` is issued.
- `running` = state[0]. `freeze` = (state == LAP). Both are decoded from the state register, so they are glitch-free.

## Timing
- Reset values: state=IDLE, `pcnt`=0, `tick`=0, `clr`=0, `freeze`=0, `running`=0, prev_*=1.
- A press seen at rising edge k (level 1, prev 0) updates state at edge k. The new state, `running` and `freeze` are visible from edge k through k+1.
- `clr` is registered: high exactly for the cycle after the edge that accepted the clear press.
- `tick` is registered: high for the one cycle after the edge at which `pcnt` wrapped from TICK_DIV-1 to 0.
- First `tick` after entering RUN from IDLE: asserted TICK_DIV cycles after the state change (pcnt counts 0…TICK_DIV-1). Steady-state period is TICK_DIV cycles.
- Pausing on the same edge `pcnt` would wrap: the transition wins, there is no wrap, and `pcnt` holds TICK_DIV-1. The tick is issued on the first counting cycle after resume.
- A button held for many cycles produces exactly one press. Levels toggling every cycle produce a press on every rising level.
- `rst` asserted mid-count: all registers take reset values at that edge, and any in-flight `tick`/`clr` is dropped.

## Test plan
- Reset/hold: `start_btn`=1 held across `rst` deassert → state stays 00 and no ticks. Release, then press → state 01 on the next edge.
- Run cadence (TICK_DIV=4): press start → `tick` high once every 4 cycles, first one 4 cycles after state=01. Count 10 ticks in 40 cycles.
- Pause/resume: with TICK_DIV=4, pause when `pcnt`=2 → no ticks for 50 cycles, `pcnt` stays 2. Resume → next tick 2 cycles after state=01.
- Lap: in RUN press lap → `freeze`=1 and ticks continue at period 4. Lap again → `freeze`=0, state 01. Start from LAP → state 10, `freeze`=0.
- Clear: in RUN press clear → no effect. In PAUSE press clear → state 00, `clr`=1 for exactly one cycle, `pcnt`=0. In IDLE clear → one `clr` pulse, state 00.
- Simultaneous presses: in PAUSE, clear+start on the same edge → IDLE with `clr` pulse. In RUN, start+lap → PAUSE, `freeze` stays 0.
